// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - BCD time types and digit arithmetic shared by the stopwatch core
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t m1;
    bcd_t m0;
    bcd_t s1;
    bcd_t s0;
    bcd_t c1;
    bcd_t c0;
  } sw_time_t;

  typedef enum logic {ST_STOPPED, ST_RUNNING} run_state_t;

  localparam sw_time_t TIME_ZERO = 24'h000000;
  localparam sw_time_t TIME_MAX  = 24'h995999;

  // Result is {carry, digit}; a digit at its limit wraps to 0 and carries.
  function automatic logic [4:0] bcd_inc(input bcd_t d, input bcd_t lim, input logic cin);
    logic [4:0] r;
    if (!cin)          r = {1'b0, d};
    else if (d >= lim) r = {1'b1, 4'd0};
    else               r = {1'b0, d + 4'd1};
    return r;
  endfunction

  function automatic logic [4:0] bcd_dec(input bcd_t d, input bcd_t lim, input logic bin);
    logic [4:0] r;
    if (!bin)           r = {1'b0, d};
    else if (d == 4'd0) r = {1'b1, lim};
    else                r = {1'b0, d - 4'd1};
    return r;
  endfunction

  function automatic sw_time_t time_inc(input sw_time_t t);
    sw_time_t   r;
    logic [4:0] s;
    s = bcd_inc(t.c0, 4'd9, 1'b1); r.c0 = s[3:0];
    s = bcd_inc(t.c1, 4'd9, s[4]); r.c1 = s[3:0];
    s = bcd_inc(t.s0, 4'd9, s[4]); r.s0 = s[3:0];
    s = bcd_inc(t.s1, 4'd5, s[4]); r.s1 = s[3:0];
    s = bcd_inc(t.m0, 4'd9, s[4]); r.m0 = s[3:0];
    s = bcd_inc(t.m1, 4'd9, s[4]); r.m1 = s[3:0];
    return r;
  endfunction

  function automatic sw_time_t time_dec(input sw_time_t t);
    sw_time_t   r;
    logic [4:0] s;
    s = bcd_dec(t.c0, 4'd9, 1'b1); r.c0 = s[3:0];
    s = bcd_dec(t.c1, 4'd9, s[4]); r.c1 = s[3:0];
    s = bcd_dec(t.s0, 4'd9, s[4]); r.s0 = s[3:0];
    s = bcd_dec(t.s1, 4'd5, s[4]); r.s1 = s[3:0];
    s = bcd_dec(t.m0, 4'd9, s[4]); r.m0 = s[3:0];
    s = bcd_dec(t.m1, 4'd9, s[4]); r.m1 = s[3:0];
    return r;
  endfunction

  function automatic bcd_t bcd_clamp(input bcd_t d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchronises an active-low button and emits one pulse per debounced press
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  // cnt tracks how long sync2 has disagreed with the accepted level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      pulse  <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      pulse <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync2;
        cnt    <= '0;
        pulse  <= ~sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/lap_stopwatch.sv
// rtl/lap_stopwatch.sv - BCD stopwatch core with lap memory, recall and countdown
module lap_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int TICK_HZ         = 100,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LAP_DEPTH       = 8,
  parameter int HOLD_TICKS      = 200
) (
  input  logic                           CLOCK_50,
  input  logic                           key_reset,
  input  logic                           key_start_pause,
  input  logic                           key_lap,
  input  logic                           key_recall,
  input  logic                           mode_down,
  input  logic [7:0]                     preset_min,
  output logic [23:0]                    disp_bcd,
  output logic                           running,
  output logic                           holding,
  output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count,
  output logic                           lap_full,
  output logic                           expired,
  output logic                           overflow
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LCW = $clog2(LAP_DEPTH + 1);
  localparam int IW  = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
  localparam int HW  = $clog2(HOLD_TICKS + 1);

  logic p_start, p_lap, p_rec, start_p, lap_p, rec_p, tick, cleared, lap_we;
  run_state_t state_q, state_d;
  logic dir_q, dir_d, expired_q, expired_d, overflow_q, overflow_d;
  logic lap_hold_q, lap_hold_d, rec_act_q, rec_act_d;
  sw_time_t time_q, time_d, hold_time_q, hold_time_d, disp_q;
  logic [PW-1:0]  presc_q, presc_d;
  logic [LCW-1:0] lap_cnt_q, lap_cnt_d;
  logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [IW-1:0]  rec_idx_q, rec_idx_d;
  sw_time_t lap_mem [LAP_DEPTH];

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk(CLOCK_50), .rst(key_reset), .key_n(key_start_pause), .pulse(p_start));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
    .clk(CLOCK_50), .rst(key_reset), .key_n(key_lap), .pulse(p_lap));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_recall (
    .clk(CLOCK_50), .rst(key_reset), .key_n(key_recall), .pulse(p_rec));

  assign running   = (state_q == ST_RUNNING);
  assign holding   = lap_hold_q | rec_act_q;
  assign lap_count = lap_cnt_q;
  assign lap_full  = (lap_cnt_q == LCW'(LAP_DEPTH));
  assign expired   = expired_q;
  assign overflow  = overflow_q;
  assign disp_bcd  = disp_q;
  assign tick      = running && (presc_q == PW'(TICK_DIV - 1));
  assign cleared   = (time_q == TIME_ZERO) && (lap_cnt_q == '0);

  always_comb begin
    state_d = state_q;  dir_d = dir_q;  expired_d = expired_q;  overflow_d = overflow_q;
    time_d = time_q;  lap_cnt_d = lap_cnt_q;  lap_hold_d = lap_hold_q;  hold_cnt_d = hold_cnt_q;
    hold_time_d = hold_time_q;  rec_act_d = rec_act_q;  rec_idx_d = rec_idx_q;
    lap_we = 1'b0;
    presc_d = '0;
    start_p = p_start;
    lap_p   = p_lap & ~p_start;
    rec_p   = p_rec & ~p_start & ~p_lap;

    if (running) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        if (dir_q) begin
          time_d = time_dec(time_q);
          if (time_d == TIME_ZERO) begin expired_d = 1'b1; state_d = ST_STOPPED; end
        end else begin
          time_d = time_inc(time_q);
          if (time_d == TIME_MAX) begin overflow_d = 1'b1; state_d = ST_STOPPED; end
        end
        if (lap_hold_q) begin
          hold_cnt_d = hold_cnt_q - HW'(1);
          if (hold_cnt_q == HW'(1)) lap_hold_d = 1'b0;
        end
      end
    end

    if (start_p) begin
      rec_act_d = 1'b0;
      presc_d   = '0;
      if (running) begin
        state_d = ST_STOPPED;
      end else begin
        expired_d  = 1'b0;
        overflow_d = 1'b0;
        if (cleared) begin
          dir_d = mode_down;
          if (mode_down) begin
            time_d    = TIME_ZERO;
            time_d.m1 = bcd_clamp(preset_min[7:4]);
            time_d.m0 = bcd_clamp(preset_min[3:0]);
          end
        end
        // Refuse to start from a terminal value so the counter never wraps.
        if (dir_d && time_d == TIME_ZERO)       expired_d  = 1'b1;
        else if (!dir_d && time_d == TIME_MAX)  overflow_d = 1'b1;
        else                                    state_d    = ST_RUNNING;
      end
    end else if (lap_p) begin
      if (running) begin
        if (!lap_full) begin
          lap_we      = 1'b1;
          lap_cnt_d   = lap_cnt_q + LCW'(1);
          hold_time_d = time_q;
          lap_hold_d  = 1'b1;
          hold_cnt_d  = HW'(HOLD_TICKS);
        end
      end else begin
        time_d = TIME_ZERO;  lap_cnt_d = '0;  lap_hold_d = 1'b0;  hold_cnt_d = '0;
        rec_act_d = 1'b0;  rec_idx_d = '0;  expired_d = 1'b0;  overflow_d = 1'b0;  dir_d = 1'b0;
      end
    end else if (rec_p && !running && lap_cnt_q != '0) begin
      lap_hold_d = 1'b0;
      if (!rec_act_q) begin
        rec_act_d = 1'b1;
        rec_idx_d = '0;
      end else if (LCW'(rec_idx_q) == lap_cnt_q - LCW'(1)) begin
        rec_act_d = 1'b0;
      end else begin
        rec_idx_d = rec_idx_q + IW'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge key_reset) begin
    if (key_reset) begin
      state_q <= ST_STOPPED;  dir_q <= 1'b0;  expired_q <= 1'b0;  overflow_q <= 1'b0;
      time_q <= TIME_ZERO;  presc_q <= '0;  lap_cnt_q <= '0;  lap_hold_q <= 1'b0;
      hold_cnt_q <= '0;  hold_time_q <= TIME_ZERO;  rec_act_q <= 1'b0;  rec_idx_q <= '0;
      disp_q <= TIME_ZERO;
    end else begin
      state_q <= state_d;  dir_q <= dir_d;  expired_q <= expired_d;  overflow_q <= overflow_d;
      time_q <= time_d;  presc_q <= presc_d;  lap_cnt_q <= lap_cnt_d;  lap_hold_q <= lap_hold_d;
      hold_cnt_q <= hold_cnt_d;  hold_time_q <= hold_time_d;  rec_act_q <= rec_act_d;
      rec_idx_q <= rec_idx_d;
      disp_q <= rec_act_q ? lap_mem[rec_idx_q] : (lap_hold_q ? hold_time_q : time_q);
    end
  end

  // Lap contents survive reset; lap_count alone decides what is readable.
  always_ff @(posedge CLOCK_50) begin
    if (lap_we) lap_mem[lap_cnt_q[IW-1:0]] <= time_q;
  end

endmodule

// File: tb/tb_lap_stopwatch.sv
// tb/tb_lap_stopwatch.sv - self-checking bench for lap_stopwatch
module tb_lap_stopwatch;

  localparam int CLK_HZ = 1000, TICK_HZ = 100, DEB = 4, DEPTH = 4, HOLD = 5;
  localparam int TDIV = CLK_HZ / TICK_HZ;

  logic        CLOCK_50 = 1'b0;
  logic        key_reset = 1'b1, key_start_pause = 1'b1, key_lap = 1'b1, key_recall = 1'b1;
  logic        mode_down = 1'b0;
  logic [7:0]  preset_min = 8'h00;
  logic [23:0] disp_bcd;
  logic        running, holding, lap_full, expired, overflow;
  logic [2:0]  lap_count;
  int cyc = 0, total = 0, bad = 0;

  lap_stopwatch #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DEBOUNCE_CYCLES(DEB),
                  .LAP_DEPTH(DEPTH), .HOLD_TICKS(HOLD)) dut (
    .CLOCK_50(CLOCK_50), .key_reset(key_reset), .key_start_pause(key_start_pause),
    .key_lap(key_lap), .key_recall(key_recall), .mode_down(mode_down),
    .preset_min(preset_min), .disp_bcd(disp_bcd), .running(running), .holding(holding),
    .lap_count(lap_count), .lap_full(lap_full), .expired(expired), .overflow(overflow));

  always #5 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: cyc=%0d limit reached", cyc);
    $fatal(1);
  end

  function automatic logic [23:0] cs2bcd(input int cs);
    int m, s, c;
    m = cs / 6000; s = (cs / 100) % 60; c = cs % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  task automatic step(); @(posedge CLOCK_50); #1; endtask
  task automatic wait_until(input int t); while (cyc < t) step(); endtask
  task automatic drive_keys(input logic [2:0] m, input logic v);
    if (m[0]) key_start_pause = v;
    if (m[1]) key_lap = v;
    if (m[2]) key_recall = v;
  endtask
  task automatic key_down(input logic [2:0] m, output int act);
    drive_keys(m, 1'b0);
    act = cyc + 2 + DEB + 1;
    wait_until(act);
  endtask
  task automatic key_up(input logic [2:0] m);
    drive_keys(m, 1'b1);
    repeat (2 + DEB + 2) step();
  endtask
  task automatic do_clear();
    int a;
    key_down(3'b010, a); key_up(3'b010);
  endtask

  task automatic test_reset();
    key_reset = 1'b1; repeat (3) step();
    total++;
    if ({disp_bcd, running, holding, lap_count, lap_full, expired, overflow} !== 32'h0) begin
      bad++; $display("FAIL reset_state: got=%h want=0",
        {disp_bcd, running, holding, lap_count, lap_full, expired, overflow});
    end
    key_reset = 1'b0; step();
  endtask

  task automatic test_count();
    int s, p; logic [23:0] exp;
    key_down(3'b001, s);
    total++; if (running !== 1'b1) begin bad++; $display("FAIL start_running: got=%b want=1", running); end
    key_up(3'b001);
    wait_until(s + 1000 * TDIV + 1);
    total++; if (disp_bcd !== 24'h001000) begin bad++; $display("FAIL count_10s: got=%h want=001000", disp_bcd); end
    repeat ($urandom_range(0, 9)) step();
    key_down(3'b001, p);
    total++; if (running !== 1'b0) begin bad++; $display("FAIL pause_running: got=%b want=0", running); end
    exp = cs2bcd((p - s) / TDIV);
    step();
    total++; if (disp_bcd !== exp) begin bad++; $display("FAIL pause_value: got=%h want=%h", disp_bcd, exp); end
    key_up(3'b001); repeat (20) step();
    total++; if (disp_bcd !== exp) begin bad++; $display("FAIL pause_frozen: got=%h want=%h", disp_bcd, exp); end
  endtask

  task automatic test_debounce();
    int n, first, c0;
    n = 0; first = -1;
    for (int i = 0; i < 12; i++) begin
      key_recall = i[1]; step();
      if (dut.u_db_recall.pulse) n++;
    end
    key_recall = 1'b0; c0 = cyc;
    for (int j = 0; j < 20; j++) begin
      step();
      if (dut.u_db_recall.pulse) begin n++; if (first < 0) first = cyc - c0; end
    end
    total++; if (first !== 2 + DEB) begin bad++; $display("FAIL debounce_latency: got=%0d want=%0d", first, 2 + DEB); end
    key_recall = 1'b1;
    for (int j = 0; j < 12; j++) begin step(); if (dut.u_db_recall.pulse) n++; end
    total++; if (n !== 1) begin bad++; $display("FAIL debounce_pulses: got=%0d want=1", n); end
    total++; if (holding !== 1'b0) begin bad++; $display("FAIL recall_no_laps: got=%b want=0", holding); end
  endtask

  task automatic test_random_pause();
    int s, p, acc; logic [23:0] exp;
    do_clear();
    total++; if (disp_bcd !== 24'h0) begin bad++; $display("FAIL clear_disp: got=%h want=0", disp_bcd); end
    acc = 0;
    for (int r = 0; r < 4; r++) begin
      key_down(3'b001, s); key_up(3'b001);
      repeat ($urandom_range(20, 300)) step();
      key_down(3'b001, p);
      acc += (p - s) / TDIV;
      exp = cs2bcd(acc);
      step();
      total++; if (disp_bcd !== exp) begin bad++; $display("FAIL pause_accum%0d: got=%h want=%h", r, disp_bcd, exp); end
      key_up(3'b001);
    end
  endtask

  task automatic test_laps();
    int s, a, p, live, q[$]; logic stored; logic [23:0] exp;
    do_clear();
    key_down(3'b001, s); key_up(3'b001);
    for (int i = 1; i <= 5; i++) begin
      wait_until(s + 100 * i + $urandom_range(1, 9) - (2 + DEB + 1));
      key_down(3'b010, a);
      stored = (q.size() < DEPTH);
      if (stored) q.push_back((a - 1 - s) / TDIV);
      total++; if (lap_count !== 3'(q.size())) begin bad++; $display("FAIL lap_count%0d: got=%0d want=%0d", i, lap_count, q.size()); end
      step();
      total++; if (holding !== stored) begin bad++; $display("FAIL lap_hold%0d: got=%b want=%b", i, holding, stored); end
      if (stored) begin
        exp = cs2bcd(q[$]);
        total++; if (disp_bcd !== exp) begin bad++; $display("FAIL lap_disp%0d: got=%h want=%h", i, disp_bcd, exp); end
      end
      key_up(3'b010);
      wait_until(s + 100 * i + HOLD * TDIV - 1);
      total++; if (holding !== stored) begin bad++; $display("FAIL hold_end_m1_%0d: got=%b want=%b", i, holding, stored); end
      wait_until(s + 100 * i + HOLD * TDIV);
      total++; if (holding !== 1'b0) begin bad++; $display("FAIL hold_end_%0d: got=%b want=0", i, holding); end
    end
    total++; if (lap_full !== 1'b1) begin bad++; $display("FAIL lap_full: got=%b want=1", lap_full); end
    key_down(3'b001, p); live = (p - s) / TDIV; key_up(3'b001);
    for (int j = 0; j < 5; j++) begin
      key_down(3'b100, a); step();
      exp = (j < q.size()) ? cs2bcd(q[j]) : cs2bcd(live);
      total++; if (disp_bcd !== exp) begin bad++; $display("FAIL recall_disp%0d: got=%h want=%h", j, disp_bcd, exp); end
      total++; if (holding !== (j < q.size())) begin bad++; $display("FAIL recall_hold%0d: got=%b want=%b", j, holding, j < q.size()); end
      key_up(3'b100);
    end
  endtask

  task automatic test_countdown();
    int s, a;
    do_clear();
    mode_down = 1'b1; preset_min = 8'h01;
    key_down(3'b001, s);
    mode_down = 1'($urandom_range(0, 1));
    key_up(3'b001);
    wait_until(s + 150 * TDIV + 1);
    total++; if (disp_bcd !== cs2bcd(5850)) begin bad++; $display("FAIL down_mid: got=%h want=%h", disp_bcd, cs2bcd(5850)); end
    wait_until(s + 6000 * TDIV - 1);
    total++; if ({expired, running} !== 2'b01) begin bad++; $display("FAIL down_before0: got=%b want=01", {expired, running}); end
    wait_until(s + 6000 * TDIV);
    total++; if ({expired, running} !== 2'b10) begin bad++; $display("FAIL down_expired: got=%b want=10", {expired, running}); end
    step();
    total++; if (disp_bcd !== 24'h0) begin bad++; $display("FAIL down_zero: got=%h want=0", disp_bcd); end
    do_clear();
    total++; if (expired !== 1'b0) begin bad++; $display("FAIL clear_expired: got=%b want=0", expired); end
    mode_down = 1'b1; preset_min = 8'h00;
    key_down(3'b001, a);
    total++; if ({expired, running} !== 2'b10) begin bad++; $display("FAIL preset00: got=%b want=10", {expired, running}); end
    key_up(3'b001); do_clear();
    preset_min = 8'hA3;
    key_down(3'b001, a); step();
    total++; if (disp_bcd !== 24'h930000) begin bad++; $display("FAIL preset_clamp: got=%h want=930000", disp_bcd); end
    key_up(3'b001); key_down(3'b001, a); key_up(3'b001);
    do_clear(); mode_down = 1'b0;
  endtask

  task automatic test_overflow();
    int s, a;
    key_down(3'b001, a); key_up(3'b001); key_down(3'b001, a); key_up(3'b001);
    force dut.time_q = 24'h995995; step(); release dut.time_q; step();
    key_down(3'b001, s); key_up(3'b001);
    wait_until(s + 4 * TDIV - 1);
    total++; if ({overflow, running} !== 2'b01) begin bad++; $display("FAIL ovf_before: got=%b want=01", {overflow, running}); end
    wait_until(s + 4 * TDIV);
    total++; if ({overflow, running} !== 2'b10) begin bad++; $display("FAIL ovf_flag: got=%b want=10", {overflow, running}); end
    repeat (30) step();
    total++; if (disp_bcd !== 24'h995999) begin bad++; $display("FAIL ovf_held: got=%h want=995999", disp_bcd); end
    key_down(3'b010, a); step();
    total++;
    if ({disp_bcd, running, holding, lap_count, lap_full, expired, overflow} !== 32'h0) begin
      bad++; $display("FAIL stopped_clear: got=%h want=0",
        {disp_bcd, running, holding, lap_count, lap_full, expired, overflow});
    end
    key_up(3'b010);
  endtask

  task automatic test_same_cycle_and_reset();
    int a; logic [23:0] exp;
    key_down(3'b011, a);
    total++; if ({running, holding, lap_count} !== 5'b10000) begin bad++; $display("FAIL same_cycle: got=%b want=10000", {running, holding, lap_count}); end
    key_up(3'b011);
    repeat (60) step();
    exp = cs2bcd((cyc - 1 - a) / TDIV);
    total++; if (disp_bcd !== exp) begin bad++; $display("FAIL pre_reset_disp: got=%h want=%h", disp_bcd, exp); end
    #3 key_reset = 1'b1;
    #1;
    total++;
    if ({disp_bcd, running, holding, lap_count, lap_full, expired, overflow} !== 32'h0) begin
      bad++; $display("FAIL async_reset: got=%h want=0",
        {disp_bcd, running, holding, lap_count, lap_full, expired, overflow});
    end
    step(); key_reset = 1'b0; step();
  endtask

  initial begin
    test_reset();
    test_count();
    test_debounce();
    test_random_pause();
    test_laps();
    test_countdown();
    test_overflow();
    test_same_cycle_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lap_stopwatch.md
# lap_stopwatch

Parametrised single-clock stopwatch core with lap memory, lap recall and a countdown mode. It takes raw active-low pushbuttons and drives six BCD digits (MM SS CC) plus status flags. The board top feeds `disp_bcd` into the existing per-digit `sevenseg` decoders. All timing derives from clock enables on `CLOCK_50`; no derived clocks.

## Interface
- `CLK_HZ`, 50_000_000: input clock frequency.
- `TICK_HZ`, 100: count resolution in Hz; `TICK_DIV = CLK_HZ/TICK_HZ`, must divide exactly.
- `DEBOUNCE_CYCLES`, 1_000_000: cycles a key must be stable (20 ms).
- `LAP_DEPTH`, 8: lap entries stored (≥1).
- `HOLD_TICKS`, 200: ticks a captured lap stays on display.

Ports:
- `CLOCK_50`  in  1  sole clock.
- `key_reset`  in  1  asynchronous, active-high reset.
- `key_start_pause`  in  1  raw button, active-low.
- `key_lap`  in  1  raw button, active-low; lap when running, clear when stopped.
- `key_recall`  in  1  raw button, active-low.
- `mode_down`  in  1  level; sampled only at start from cleared state.
- `preset_min`  in  8  BCD minutes for countdown.
- `disp_bcd`  out  24  {m1,m0,s1,s0,c1,c0}, 4-bit BCD each.
- `running`  out  1  counter advancing.
- `holding`  out  1  display shows a lap, not live time.
- `lap_count`  out  $clog2(LAP_DEPTH+1)  laps stored.
- `lap_full`  out  1  `lap_count == LAP_DEPTH`.
- `expired`  out  1  countdown reached zero.
- `overflow`  out  1  count-up saturated at 99:59.99.

## Operation
- Each key passes through `key_debounce`, which emits a one-cycle press pulse. Same-cycle priority: reset > start_pause > lap > recall. Only the highest pulse acts; the others are discarded.
- **start_pause**: toggles `running`.
  - Start from cleared state (time 0, no laps) with `mode_down=1` loads `preset_min`:00.00 and sets direction down. Preset digits >9 clamp to 9.
  - Preset 00 gives immediate `expired=1`, `running=0`.
  - Start clears `expired` and `overflow`, and exits recall.
- **Count**: time is BCD, CC 00–99, SS 00–59, MM 00–99.
  - Up: 99:59.99 is held. It sets `overflow=1` and `running=0`.
  - Down: on reaching 00:00.00 it sets `expired=1` and `running=0`.
- **lap while running**:
  - If not full: write current time to lap RAM[`lap_count`], increment `lap_count`, set `holding=1` showing the captured value for HOLD_TICKS ticks. A new lap restarts the hold.
  - If full: no write, no hold.
- **lap while stopped**: clear time, laps, hold, recall, `expired`, `overflow`. Direction returns to up.
- **recall**: acts only while stopped with `lap_count>0`, ignored otherwise.
  - Steps a display index live→0→1…→`lap_count-1`→live.
  - `holding=1` while the index is not live.
- Reset mid-count: all state clears immediately; lap contents become don't-care but are unreadable (`lap_count=0`).

## Timing
- Reset values: `disp_bcd=0`, all flags 0, `lap_count=0`, direction up, prescaler 0.
- Debounce: raw input is double-flopped. The pulse asserts in the cycle the synchronised level has held low for DEBOUNCE_CYCLES consecutive cycles, i.e. 2+DEBOUNCE_CYCLES cycles after a clean falling edge. There is one pulse per press; release is debounced identically with no pulse.
- Prescaler: held at 0 while stopped. It counts 0..TICK_DIV-1 while running, and the tick fires on TICK_DIV-1. The first increment is therefore TICK_DIV cycles after the start pulse. Pause discards the partial tick.
- Time, flags and lap write update on the tick or event cycle. `disp_bcd` is registered and follows one cycle later.
- Hold counter decrements on ticks only. The display returns to live on the tick where it reaches 0.

## Structure
- Package `stopwatch_pkg`:
  - `bcd_t` (4-bit).
  - `sw_time_t` packed struct of six digits.
  - `TIME_ZERO`, `TIME_MAX`.
  - BCD increment/decrement functions with carry/borrow.
- Sub-module `key_debounce` (parameter DEBOUNCE_CYCLES), instantiated three times.
- Lap storage is a plain register array indexed by `lap_count`, no write port beyond that.

## Test plan
Test parameters: CLK_HZ=1000, TICK_HZ=100, DEBOUNCE_CYCLES=4, LAP_DEPTH=4, HOLD_TICKS=5.
- Start press, wait 1000 ticks → `disp_bcd`=00:10.00, pause freezes it, `running=0`.
- Bounce key 0/1 every 2 cycles then hold low → exactly one pulse, 6 cycles after stable low.
- Running, 5 laps at ticks 10,20,30,40,50 → `lap_count=4`, `lap_full=1`, fifth ignored. `holding` drops 5 ticks after each lap. Stop, recall ×5 → 00:00.10, .20, .30, .40, live.
- Cleared, `mode_down=1`, preset 0x01, start → after 6000 ticks 00:00.00, `expired=1`, `running=0`. Preset 0x00 → `expired` next cycle.
- Preload near 99:59.99 → saturates, `overflow=1`. Lap while stopped → all zero, flags clear.
- Start and lap pulses same cycle → only start acts. `key_reset` mid-count → all outputs reset values asynchronously.
